// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clk_div_pkg;

  localparam int unsigned DIV_W_DEF        = 32;
  localparam int unsigned CLK_HZ           = 100_000_000;
  localparam int unsigned DEFAULT_HALF_CYC = 2_500_000;

  // Half-period in clk cycles for a target output frequency.
  function automatic logic [DIV_W_DEF-1:0] half_for_hz(input int unsigned hz);
    return DIV_W_DEF'(CLK_HZ / (2 * hz));
  endfunction

  function automatic logic [DIV_W_DEF-1:0] eff_half(input logic [DIV_W_DEF-1:0] h);
    return (h == '0) ? DIV_W_DEF'(1) : h;
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: half-period counter, shadow/active divisor, output and strobe flops.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int unsigned      DIV_W        = DIV_W_DEF,
  parameter logic [DIV_W-1:0] DEFAULT_HALF = DIV_W'(DEFAULT_HALF_CYC)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             ld,
  input  logic [DIV_W-1:0] ld_half,
  output logic             divided_clk,
  output logic             tick,
  output logic             rise
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] active_half;
  logic [DIV_W-1:0] shadow_half;
  logic             terminal;

  // Half-periods of 0 and 1 both terminate every cycle (clk/2).
  assign terminal = (active_half <= DIV_W'(1)) || (cnt == active_half - DIV_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      divided_clk <= 1'b0;
      tick        <= 1'b0;
      rise        <= 1'b0;
      active_half <= DEFAULT_HALF;
      shadow_half <= DEFAULT_HALF;
    end else begin
      if (ld) shadow_half <= ld_half;
      // active_half takes the pre-load shadow value when a load coincides with a boundary.
      if (!en || sync) begin
        cnt         <= '0;
        divided_clk <= 1'b0;
        tick        <= 1'b0;
        rise        <= 1'b0;
        active_half <= shadow_half;
      end else if (terminal) begin
        cnt         <= '0;
        divided_clk <= ~divided_clk;
        tick        <= 1'b1;
        rise        <= ~divided_clk;
        active_half <= shadow_half;
      end else begin
        cnt  <= cnt + DIV_W'(1);
        tick <= 1'b0;
        rise <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_divider_multi.sv
// NUM_CH independent programmable square-wave dividers with shared phase-align sync.
module clk_divider_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned      NUM_CH       = 4,
  parameter int unsigned      DIV_W        = DIV_W_DEF,
  parameter logic [DIV_W-1:0] DEFAULT_HALF = DIV_W'(DEFAULT_HALF_CYC),
  localparam int unsigned     CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              ld,
  input  logic [CH_W-1:0]   ld_ch,
  input  logic [DIV_W-1:0]  ld_half,
  output logic [NUM_CH-1:0] divided_clk,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] rise
);

  // ld_ch codes at or above NUM_CH match no channel and are dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_channel #(
      .DIV_W        (DIV_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en[i]),
      .sync        (sync),
      .ld          (ld && (ld_ch == CH_W'(i))),
      .ld_half     (ld_half),
      .divided_clk (divided_clk[i]),
      .tick        (tick[i]),
      .rise        (rise[i])
    );
  end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Directed bench for clk_divider_multi with DEFAULT_HALF=5; a NUM_CH=3 copy covers out-of-range ld_ch.
module tb_clk_divider_multi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  en;
  logic        sync;
  logic        ld;
  logic [1:0]  ld_ch;
  logic [31:0] ld_half;
  logic [3:0]  divided_clk;
  logic [3:0]  tick;
  logic [3:0]  rise;

  logic [2:0]  en3;
  logic        sync3;
  logic        ld3;
  logic [1:0]  ld_ch3;
  logic [31:0] ld_half3;
  logic [2:0]  dclk3;
  logic [2:0]  tick3;
  logic [2:0]  rise3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clk_divider_multi #(.NUM_CH(4), .DIV_W(32), .DEFAULT_HALF(32'd5)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .ld(ld), .ld_ch(ld_ch),
    .ld_half(ld_half), .divided_clk(divided_clk), .tick(tick), .rise(rise)
  );

  clk_divider_multi #(.NUM_CH(3), .DIV_W(32), .DEFAULT_HALF(32'd5)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en(en3), .sync(sync3), .ld(ld3), .ld_ch(ld_ch3),
    .ld_half(ld_half3), .divided_clk(dclk3), .tick(tick3), .rise(rise3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 4'b0001; sync = 1'b0; ld = 1'b0; ld_ch = '0; ld_half = '0;
    en3 = 3'b111; sync3 = 1'b0; ld3 = 1'b0; ld_ch3 = '0; ld_half3 = '0;
    step();
    step();
    check("rst_dclk", 32'(divided_clk), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_rise", 32'(rise), 32'd0);
    check("rst_dclk3", 32'(dclk3), 32'd0);

    // Test 1: reset release, default half 5; ld_ch=3 on the 3-channel copy must be dropped
    rst_n = 1'b1;
    ld3 = 1'b1; ld_ch3 = 2'd3; ld_half3 = 32'd1;
    for (int e = 1; e <= 15; e++) begin
      step();
      ld3 = 1'b0;
      check($sformatf("t1_dclk0_e%0d", e), 32'(divided_clk[0]), 32'((e >= 5 && e < 10) || e >= 15));
      check($sformatf("t1_tick0_e%0d", e), 32'(tick[0]), 32'(e % 5 == 0));
      check($sformatf("t1_rise0_e%0d", e), 32'(rise[0]), 32'(e == 5 || e == 15));
      check($sformatf("t1_idle_e%0d", e), 32'(divided_clk[3:1]), 32'd0);
      check($sformatf("t1_dclk3_e%0d", e), 32'(dclk3), ((e >= 5 && e < 10) || e >= 15) ? 32'h7 : 32'h0);
      check($sformatf("t1_tick3_e%0d", e), 32'(tick3), (e % 5 == 0) ? 32'h7 : 32'h0);
    end

    // Test 2: load H=3 on ch0 while cnt=1; current half stays 5
    step();
    ld = 1'b1; ld_ch = 2'd0; ld_half = 32'd3;
    for (int e = 17; e <= 29; e++) begin
      step();
      ld = 1'b0;
      check($sformatf("t2_dclk0_e%0d", e), 32'(divided_clk[0]),
            32'(e < 20 || (e >= 23 && e < 26) || e >= 29));
      check($sformatf("t2_tick0_e%0d", e), 32'(tick[0]), 32'(e == 20 || e == 23 || e == 26 || e == 29));
    end

    // Test 3: enable ch1 and load H=0; clk/2 after the first 5-cycle half
    en = 4'b0011; ld = 1'b1; ld_ch = 2'd1; ld_half = 32'd0;
    for (int e = 30; e <= 40; e++) begin
      step();
      ld = 1'b0;
      check($sformatf("t3_dclk1_e%0d", e), 32'(divided_clk[1]), 32'(e >= 34 && e % 2 == 0));
      check($sformatf("t3_tick1_e%0d", e), 32'(tick[1]), 32'(e >= 34));
      check($sformatf("t3_rise1_e%0d", e), 32'(rise[1]), 32'(e >= 34 && e % 2 == 0));
    end

    // Test 4: ch0 H=5, ch2 H=3 free-running, then sync
    ld = 1'b1; ld_ch = 2'd0; ld_half = 32'd5;
    step();
    ld_ch = 2'd2; ld_half = 32'd3;
    step();
    ld = 1'b0; en = 4'b0101;
    repeat (20) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    check("t4_sync_dclk", 32'({divided_clk[2], divided_clk[0]}), 32'd0);
    check("t4_sync_tick", 32'({tick[2], tick[0]}), 32'd0);
    for (int k = 1; k <= 6; k++) begin
      step();
      check($sformatf("t4_dclk0_k%0d", k), 32'(divided_clk[0]), 32'(k >= 5));
      check($sformatf("t4_rise0_k%0d", k), 32'(rise[0]), 32'(k == 5));
      check($sformatf("t4_dclk2_k%0d", k), 32'(divided_clk[2]), 32'(k >= 3 && k < 6));
      check($sformatf("t4_rise2_k%0d", k), 32'(rise[2]), 32'(k == 3));
    end

    // Test 5: drop en[0] while high for 7 cycles, then re-enable
    en = 4'b0100;
    for (int d = 1; d <= 7; d++) begin
      step();
      check($sformatf("t5_off_dclk0_d%0d", d), 32'(divided_clk[0]), 32'd0);
      check($sformatf("t5_off_tick0_d%0d", d), 32'(tick[0]), 32'd0);
    end
    en = 4'b0101;
    for (int m = 1; m <= 5; m++) begin
      step();
      check($sformatf("t5_dclk0_m%0d", m), 32'(divided_clk[0]), 32'(m == 5));
      check($sformatf("t5_rise0_m%0d", m), 32'(rise[0]), 32'(m == 5));
    end

    // Test 6: asynchronous reset between edges clears outputs immediately
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_dclk", 32'(divided_clk), 32'd0);
    check("t6_async_tick", 32'(tick), 32'd0);
    check("t6_async_rise", 32'(rise), 32'd0);
    check("t6_async_dclk3", 32'(dclk3), 32'd0);
    step();
    check("t6_held_dclk", 32'(divided_clk), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
